// File: rtl/reciprocal_pkg.sv
// Shared types and constants for the fixed-point reciprocal unit.
// Optional rounding is selected in reciprocal_fx by the RECIPROCAL_ROUND_EN macro.
package reciprocal_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFin,
    StDone
  } recip_state_t;

  localparam int unsigned SatBits = 128;

  // Dividend width: operand width plus room for the doubled fractional scaling.
  function automatic int unsigned calc_dw(input int unsigned width, input int unsigned frac_bits);
    return width + 2 * frac_bits;
  endfunction

  function automatic logic [SatBits-1:0] sat_max_pos(input int unsigned width);
    return (SatBits'(1) << (width - 1)) - SatBits'(1);
  endfunction

  function automatic logic [SatBits-1:0] sat_min_mag(input int unsigned width);
    return SatBits'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial subtract.
module udiv_step #(
  parameter int unsigned RW = 33
) (
  input  logic [RW-1:0] rem_i,
  input  logic [RW-1:0] div_i,
  input  logic          bit_i,
  output logic [RW-1:0] rem_o,
  output logic          q_o
);

  logic [RW:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = shifted >= {1'b0, div_i};
    rem_o   = q_o ? RW'(shifted - {1'b0, div_i}) : RW'(shifted);
  end

endmodule

// File: rtl/reciprocal_fx.sv
// Handshaked signed fixed-point reciprocal z = NUMERATOR / x, one quotient bit per cycle.
// Define RECIPROCAL_ROUND_EN to round the magnitude to nearest instead of truncating.
module reciprocal_fx
  import reciprocal_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 14,
  parameter int unsigned NUMERATOR = 32'h100
) (
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] x_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] z_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  localparam int unsigned DW   = calc_dw(WIDTH, FRAC_BITS);
  localparam int unsigned CntW = $clog2(DW);

  localparam logic [DW-1:0]    QMaxPos = DW'(sat_max_pos(WIDTH));
  localparam logic [DW-1:0]    QMinMag = DW'(sat_min_mag(WIDTH));
  localparam logic [WIDTH-1:0] ZMaxPos = WIDTH'(sat_max_pos(WIDTH));
  localparam logic [WIDTH-1:0] ZMinNeg = WIDTH'(sat_min_mag(WIDTH));

  recip_state_t     state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   div_q, div_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH:0]   x_ext;
  logic [DW-1:0]    mag;

  udiv_step #(
    .RW (WIDTH + 1)
  ) u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .bit_i (dvd_q[DW-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    x_ext = {x_q[WIDTH-1], x_q};
`ifdef RECIPROCAL_ROUND_EN
    // Round half away from zero on the magnitude: increment when 2*rem >= divisor.
    mag = quo_q + DW'({rem_q, 1'b0} >= {1'b0, div_q});
`else
    mag = quo_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    valid_d = valid_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (valid_i && ready_q) begin
          x_d     = x_i;
          state_d = StPrep;
        end
      end
      StPrep: begin
        neg_d   = x_q[WIDTH-1];
        div_d   = x_q[WIDTH-1] ? -x_ext : x_ext;
        dvd_d   = DW'(NUMERATOR) << (2 * FRAC_BITS);
        quo_d   = '0;
        rem_d   = '0;
        cnt_d   = CntW'(DW - 1);
        zero_d  = (x_q == '0);
        state_d = (x_q == '0) ? StFin : StCalc;
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = {quo_q[DW-2:0], step_q};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StFin;
      end
      StFin: begin
        dbz_d = zero_q;
        ovf_d = 1'b0;
        if (zero_q) begin
          z_d = ZMaxPos;
        end else if (!neg_q && mag > QMaxPos) begin
          z_d   = ZMaxPos;
          ovf_d = 1'b1;
        end else if (neg_q && mag > QMinMag) begin
          z_d   = ZMinNeg;
          ovf_d = 1'b1;
        end else begin
          z_d = neg_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
        end
        valid_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so ready_o stays low throughout reset and rises one cycle after release.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      x_q     <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      z_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      z_q     <= z_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign z_o     = z_q;
  assign dbz_o   = dbz_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_reciprocal_fx.sv
// Self-checking bench for reciprocal_fx: directed corner cases, backpressure, reset, random operands.
module tb_reciprocal_fx;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned FRAC_BITS = 14;
  localparam int unsigned NUMERATOR = 32'h100;
  localparam int          LAT_NORM  = WIDTH + 2 * FRAC_BITS + 2;
  localparam int          LAT_DBZ   = 2;

  logic             clk = 1'b0;
  logic             reset_ni = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] x_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [WIDTH-1:0] z_o;
  logic             dbz_o;
  logic             ovf_o;

  int checks = 0;
  int failures = 0;

  reciprocal_fx #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .NUMERATOR (NUMERATOR)
  ) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .x_i      (x_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .z_o      (z_o),
    .dbz_o    (dbz_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide-integer arithmetic on the mathematical definition.
  task automatic model(input logic [31:0] x, output logic [31:0] z, output logic dbz,
                       output logic ovf);
    logic [127:0] num, mag, q, r;
    logic         neg;
    num = 128'(NUMERATOR) << (2 * FRAC_BITS);
    dbz = 1'b0;
    ovf = 1'b0;
    if (x == 32'd0) begin
      z   = 32'h7FFF_FFFF;
      dbz = 1'b1;
    end else begin
      neg = x[31];
      mag = neg ? 128'(-$signed({1'b1, x})) & 128'hFFFF_FFFF_F : 128'(x);
      q   = num / mag;
      r   = num % mag;
`ifdef RECIPROCAL_ROUND_EN
      if (2 * r >= mag) q = q + 1;
`endif
      if (!neg && q > 128'h7FFF_FFFF) begin
        z   = 32'h7FFF_FFFF;
        ovf = 1'b1;
      end else if (neg && q > 128'h8000_0000) begin
        z   = 32'h8000_0000;
        ovf = 1'b1;
      end else begin
        z = neg ? 32'(-q) : 32'(q);
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) check({tag, "_ready_timeout"}, 64'(ready_o), 64'd1);
  endtask

  // Issue x, return number of edges from the accept edge until valid_o is seen.
  task automatic issue(input logic [31:0] x, output int lat);
    valid_i = 1'b1;
    x_i     = x;
    @(posedge clk); #1;
    valid_i = 1'b0;
    x_i     = $urandom;
    lat = 0;
    while (!valid_o && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] x, input string tag);
    logic [31:0] ez;
    logic        ed, eo;
    int          lat;
    model(x, ez, ed, eo);
    wait_ready(tag);
    issue(x, lat);
    check({tag, "_latency"}, 64'(lat), 64'(ed ? LAT_DBZ : LAT_NORM));
    check({tag, "_z"}, 64'(z_o), 64'(ez));
    check({tag, "_dbz"}, 64'(dbz_o), 64'(ed));
    check({tag, "_ovf"}, 64'(ovf_o), 64'(eo));
    check({tag, "_ready_busy"}, 64'(ready_o), 64'd0);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check({tag, "_ready_back"}, 64'(ready_o), 64'd1);
    check({tag, "_valid_drop"}, 64'(valid_o), 64'd0);
  endtask

  initial begin
    logic [31:0] hold_z;
    int          lat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_z", 64'(z_o), 64'd0);
    check("rst_flags", 64'({dbz_o, ovf_o}), 64'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_rise", 64'(ready_o), 64'd1);

    // Directed cases
    run_op(32'h0000_8000, "two");
    run_op(32'hFFFF_0000, "neg_four");
    run_op(32'h0000_0000, "zero");
    run_op(32'h0000_0001, "tiny_pos");
    run_op(32'hFFFF_FFFF, "tiny_neg");
    run_op(32'h0001_8000, "six");
    run_op(32'h8000_0000, "most_neg");
    run_op(32'h7FFF_FFFF, "most_pos");

    // Literal expectations from hand-derived values
    wait_ready("lit");
    issue(32'h0000_8000, lat);
    check("lit_two_z", 64'(z_o), 64'h0020_0000);
    ready_i = 1'b1; @(posedge clk); #1; ready_i = 1'b0;
    issue(32'h0001_8000, lat);
`ifdef RECIPROCAL_ROUND_EN
    check("lit_six_z", 64'(z_o), 64'h000A_AAAB);
`else
    check("lit_six_z", 64'(z_o), 64'h000A_AAAA);
`endif
    ready_i = 1'b1; @(posedge clk); #1; ready_i = 1'b0;

    // Backpressure: result held, new operands ignored
    wait_ready("bp");
    issue(32'hFFFF_0000, lat);
    hold_z = z_o;
    check("bp_first_z", 64'(hold_z), 64'hFFF0_0000);
    for (int i = 0; i < 10; i++) begin
      valid_i = i[0];
      x_i     = $urandom;
      @(posedge clk); #1;
      check("bp_z_stable", 64'(z_o), 64'(hold_z));
      check("bp_valid_held", 64'(valid_o), 64'd1);
      check("bp_ready_low", 64'(ready_o), 64'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("bp_ready_rise", 64'(ready_o), 64'd1);
    check("bp_valid_fall", 64'(valid_o), 64'd0);

    // Reset mid-CALC, z_o currently holds a nonzero result
    valid_i = 1'b1;
    x_i     = 32'h0000_8000;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset_ni = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_z", 64'(z_o), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    run_op(32'h0000_8000, "after_rst");

    // Random operands: full range plus small magnitudes near saturation
    for (int i = 0; i < 16; i++) run_op($urandom, "rand_full");
    for (int i = 0; i < 8; i++) begin
      logic [31:0] s;
      s = $urandom_range(1, 64);
      if (i[0]) s = -s;
      run_op(s, "rand_small");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
